// File: rtl/counter_if.sv
// ============================================================================
// Module   : counter_if
// Brief    : Control and status bundle for the multi-mode counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface counter_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic [1:0]       mode;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             load;
  logic             rco;

  modport master (
    output enable,
    output mode,
    output D,
    input  Q,
    input  load,
    input  rco
  );

  modport slave (
    input  enable,
    input  mode,
    input  D,
    output Q,
    output load,
    output rco
  );
endinterface

`default_nettype wire

// File: rtl/counter.sv
// ============================================================================
// Module   : counter
// Brief    : Multi-mode counter (up 3 / down 1 / up 1 / load) with load and
//            rco pulses. Define COUNTER_SATURATE_EN to clamp instead of wrap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter #(
  parameter int WIDTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  counter_if.slave  bus
);

  localparam logic [1:0]     c_MODE_UP3  = 2'b00;
  localparam logic [1:0]     c_MODE_DN1  = 2'b01;
  localparam logic [1:0]     c_MODE_UP1  = 2'b10;
  localparam logic [1:0]     c_MODE_LOAD = 2'b11;
  localparam logic [WIDTH:0] c_ONE       = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] c_THREE     = (WIDTH+1)'(3);

  logic [WIDTH-1:0] r_q;
  logic             r_load;
  logic             r_rco;

  logic [WIDTH:0]   w_ext_q;
  logic [WIDTH:0]   w_arith;
  logic             w_out_of_range;
  logic [WIDTH-1:0] w_next_q;
  logic             w_next_load;
  logic             w_next_rco;

  assign w_ext_q = {1'b0, r_q};

  // One extra bit: its MSB flags both carry on the way up and borrow below zero.
  always_comb begin
    w_arith = w_ext_q;
    case (bus.mode)
      c_MODE_UP3: w_arith = w_ext_q + c_THREE;
      c_MODE_DN1: w_arith = w_ext_q - c_ONE;
      c_MODE_UP1: w_arith = w_ext_q + c_ONE;
      default:    w_arith = w_ext_q;
    endcase
  end

  assign w_out_of_range = w_arith[WIDTH];

  always_comb begin
    w_next_q    = r_q;
    w_next_load = 1'b0;
    w_next_rco  = 1'b0;
    if (bus.enable) begin
      if (bus.mode == c_MODE_LOAD) begin
        w_next_q    = bus.D;
        w_next_load = 1'b1;
      end else begin
        w_next_rco = w_out_of_range;
`ifdef COUNTER_SATURATE_EN
        if (w_out_of_range) begin
          w_next_q = (bus.mode == c_MODE_DN1) ? '0 : '1;
        end else begin
          w_next_q = w_arith[WIDTH-1:0];
        end
`else
        w_next_q = w_arith[WIDTH-1:0];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q    <= '0;
      r_load <= 1'b0;
      r_rco  <= 1'b0;
    end else begin
      r_q    <= w_next_q;
      r_load <= w_next_load;
      r_rco  <= w_next_rco;
    end
  end

  assign bus.Q    = r_q;
  assign bus.load = r_load;
  assign bus.rco  = r_rco;

endmodule

`default_nettype wire

// File: tb/tb_counter.sv
// ============================================================================
// Module   : tb_counter
// Brief    : Directed self-checking bench for counter; integer reference model
//            plus literal expectations. Honours COUNTER_SATURATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  // Reference state kept as plain integers
  int   m_q;
  bit   m_load;
  bit   m_rco;

  counter_if #(.WIDTH(4)) bus ();

  counter #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_step(input bit rst, input bit en,
                                     input int mode, input int d);
    int t;
    if (rst) begin
      m_q = 0; m_load = 0; m_rco = 0;
    end else if (!en) begin
      m_load = 0; m_rco = 0;
    end else if (mode == 3) begin
      m_q = d; m_load = 1; m_rco = 0;
    end else begin
      t = (mode == 0) ? m_q + 3 : (mode == 1) ? m_q - 1 : m_q + 1;
      m_load = 0;
      m_rco  = (t > 15) || (t < 0);
`ifdef COUNTER_SATURATE_EN
      m_q = (t > 15) ? 15 : (t < 0) ? 0 : t;
`else
      m_q = (t + 16) % 16;
`endif
    end
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle, advance the model, then check at the falling edge.
  task automatic step(input bit rst, input bit en, input int mode, input int d);
    reset      = rst;
    bus.enable = en;
    bus.mode   = 2'(mode);
    bus.D      = 4'(d);
    @(posedge clk);
    model_step(rst, en, mode, d);
    @(negedge clk);
    cmp("model_Q",    int'(bus.Q),    m_q);
    cmp("model_load", int'(bus.load), int'(m_load));
    cmp("model_rco",  int'(bus.rco),  int'(m_rco));
  endtask

  task automatic lit(input string name, input int q, input int l, input int r);
    cmp({name, "_Q"},    int'(bus.Q),    q);
    cmp({name, "_load"}, int'(bus.load), l);
    cmp({name, "_rco"},  int'(bus.rco),  r);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0; failures = 0;
    m_q = 0; m_load = 0; m_rco = 0;
    reset = 1'b1; bus.enable = 1'b1; bus.mode = 2'b11; bus.D = 4'd9;
    @(negedge clk);

    // Reset dominates a pending load
    step(1, 1, 3, 9);  lit("reset1", 0, 0, 0);
    step(1, 1, 3, 9);  lit("reset2", 0, 0, 0);

    // Load then count up by one across the wrap
    step(0, 1, 3, 13); lit("load13", 13, 1, 0);
    step(0, 1, 2, 0);  lit("up1_a", 14, 0, 0);
    step(0, 1, 2, 0);  lit("up1_b", 15, 0, 0);
`ifdef COUNTER_SATURATE_EN
    step(0, 1, 2, 0);  lit("up1_c", 15, 0, 1);
`else
    step(0, 1, 2, 0);  lit("up1_c", 0, 0, 1);
`endif

    // Up by three across the wrap
    step(0, 1, 3, 14); lit("load14", 14, 1, 0);
`ifdef COUNTER_SATURATE_EN
    step(0, 1, 0, 0);  lit("up3_a", 15, 0, 1);
    step(0, 1, 0, 0);  lit("up3_b", 15, 0, 1);
`else
    step(0, 1, 0, 0);  lit("up3_a", 1, 0, 1);
    step(0, 1, 0, 0);  lit("up3_b", 4, 0, 0);
`endif

    // Down by one across zero
    step(0, 1, 3, 1);  lit("load1", 1, 1, 0);
    step(0, 1, 1, 0);  lit("dn1_a", 0, 0, 0);
`ifdef COUNTER_SATURATE_EN
    step(0, 1, 1, 0);  lit("dn1_b", 0, 0, 1);
    step(0, 1, 1, 0);  lit("dn1_c", 0, 0, 1);
`else
    step(0, 1, 1, 0);  lit("dn1_b", 15, 0, 1);
    step(0, 1, 1, 0);  lit("dn1_c", 14, 0, 0);
`endif

    // Enable low holds in every mode
    step(0, 1, 3, 7);  lit("load7", 7, 1, 0);
    for (int m = 0; m < 4; m++) begin
      for (int k = 0; k < 5; k++) begin
        step(0, 0, m, 2);
        lit("hold", 7, 0, 0);
      end
    end
    step(0, 1, 2, 0);  lit("resume", 8, 0, 0);

    // Back-to-back loads keep load high
    step(0, 1, 3, 3);  lit("bb_load1", 3, 1, 0);
    step(0, 1, 3, 5);  lit("bb_load2", 5, 1, 0);

    // Up by three from 13 lands exactly on the carry
`ifdef COUNTER_SATURATE_EN
    step(0, 1, 3, 13); step(0, 1, 0, 0); lit("up3_13", 15, 0, 1);
`else
    step(0, 1, 3, 13); step(0, 1, 0, 0); lit("up3_13", 0, 0, 1);
`endif

    // Reset mid-operation
    step(0, 1, 3, 9);  lit("load9", 9, 1, 0);
    step(1, 1, 2, 0);  lit("mid_reset", 0, 0, 0);

    // Deterministic mixed sequence checked only against the model
    for (int i = 0; i < 60; i++) begin
      step(0, (i % 5) != 0, (i * 3 + i / 7) % 4, (i * 7) % 16);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
